// File: rtl/pr_timer.sv
// Purpose: programmable interval timer (CTRL/PRESET/COUNT) with one-shot and auto-reload modes and a maskable irq.
// Latency: register writes land on the next clk edge; dout and sel are combinational; irq rises P+2 edges after En is written.
// Backpressure: none; the bus is always accepted. Optional build macro TIMER_PRESCALE_EN slows the count by PRESCALE.
module pr_timer #(
    parameter logic [31:0] BASE  = 32'h0000_7F00,
    parameter int          WIDTH = 32
`ifdef TIMER_PRESCALE_EN
    ,
    parameter int          PRESCALE = 4
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        sel,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_PRESET = 2'd1;
    localparam logic [1:0] R_COUNT  = 2'd2;

    logic [1:0]       state;
    logic             en;
    logic [1:0]       mode;
    logic             im;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             irq_flag;

    logic             wr;
    logic             wr_ctrl;
    logic             wr_preset;
    logic             tick;
    logic [1:0]       reg_idx;

    // Byte-lane bits never take part in decode; the name keeps them out of unused-signal reports.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign reg_idx   = addr[3:2];
    assign sel       = (addr[31:4] == BASE[31:4]);
    assign wr        = we & sel;
    assign wr_ctrl   = wr && (reg_idx == R_CTRL);
    assign wr_preset = wr && (reg_idx == R_PRESET);
    assign irq       = im & irq_flag;

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pscnt;

    assign tick = (pscnt == PW'(PRESCALE - 1));

    // Prescaler: restarts at every reload, advances only while actively counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            pscnt <= '0;
        end else if (state == S_LOAD) begin
            pscnt <= '0;
        end else if ((state == S_CNT) && en) begin
            pscnt <= tick ? '0 : pscnt + PW'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    // FSM and register file; bus writes come last so they override FSM updates on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            en       <= 1'b0;
            mode     <= 2'd0;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        // A count of 0 (PRESET=0) expires exactly like a count of 1.
                        if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                        end else begin
                            count    <= '0;
                            irq_flag <= 1'b1;
                            state    <= S_INT;
                        end
                    end
                end
                default: begin
                    if (mode == 2'd1) begin
                        irq_flag <= 1'b0;
                        state    <= en ? S_LOAD : S_IDLE;
                    end else begin
                        en    <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase

            if (wr_ctrl) begin
                en       <= din[0];
                mode     <= din[2:1];
                im       <= din[3];
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset   <= din[WIDTH-1:0];
                irq_flag <= 1'b0;
            end
        end
    end

    // Read mux: zero when the device is not addressed and for the reserved slot.
    always_comb begin
        dout = 32'd0;
        if (sel) begin
            case (reg_idx)
                R_CTRL:   dout = {28'd0, im, mode, en};
                R_PRESET: dout = 32'(preset);
                R_COUNT:  dout = 32'(count);
                default:  dout = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/pr_timer.md
Name: pr_timer

Overview:
- Programmable interval timer on the processor-side peripheral bus, directly downstream of the CPU core.
- Consumes the core's bus outputs: address (PrAddr), write data (PrDOut) and write enable (Wen).
- Returns read data toward PrDIn and raises an interrupt request that feeds one bit of HWInt.
- Three word registers: CTRL, PRESET, COUNT; a 4-state FSM; one-shot or auto-reload modes.

Parameters:
- BASE, 32'h0000_7F00, word-aligned base address; the device occupies BASE..BASE+0xF.
- WIDTH, 32, counter and preset width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  bus address (from PrAddr).
- we  input  1  bus write enable (from Wen).
- din  input  32  bus write data (from PrDOut).
- dout  output  32  read data (toward PrDIn).
- sel  output  1  combinational: addr[31:4]==BASE[31:4].
- irq  output  1  interrupt request (to one HWInt bit).

Behaviour:
- Register map at addr[3:2]:
  - 0 = CTRL: [0] En, [2:1] Mode, [3] IM; bits [31:4] read as 0.
  - 1 = PRESET: read/write.
  - 2 = COUNT: read-only.
  - 3 = reserved: reads 0, writes ignored.
- Write enable: wr = we & sel, registered at the clk edge. Writes to COUNT are ignored.
- dout: combinational; 0 when !sel.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so irq=0 and dout=0 for an unselected address. Reset overrides everything, including a write or a count in progress.
- FSM transitions (one edge each):
  - IDLE: En=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - En=0 -> IDLE; COUNT holds.
    - Else if COUNT>1: COUNT<=COUNT-1.
    - Else (COUNT is 1 or 0): COUNT<=0, irq_flag<=1 -> INT.
  - INT, Mode 0 (one-shot): En<=0 -> IDLE; irq_flag stays set.
  - INT, Mode 1 (auto-reload): irq_flag<=0 -> LOAD if En, else IDLE.
  - Modes 2 and 3 behave as Mode 0.
- irq = IM & irq_flag. Mode 1 therefore gives a 1-cycle pulse per period.
- Timing:
  - Write of En=1 at edge E0 -> LOAD at E1 -> COUNT=P at E2 -> INT and irq at E(2+P), for P>=1.
  - PRESET=0 behaves as P=1.
  - Mode 1 period = P+2 cycles.
- irq_flag clear:
  - Any write to CTRL or PRESET clears irq_flag.
  - A CTRL write wins over a simultaneous INT-state clear of En: the written En value is kept.
- Writes while running:
  - A PRESET write during CNT does not change COUNT; it takes effect at the next LOAD.
  - Writing En=1 while already in CNT does not restart the count.
  - Writing En=0 stops the count at the next edge; COUNT is frozen and readable.
- Wrap-around: impossible; COUNT never decrements below 0.
- Simultaneous flag set and clear: a CTRL or PRESET write at the same edge as the CNT->INT transition clears the flag, i.e. the write wins.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- When defined:
  - Adds parameter PRESCALE (default 4) and an internal prescale counter.
  - The CNT decrement and the CNT->INT step happen only on edges where the prescaler reaches PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler resets to 0 on rst and on LOAD.
  - Timing becomes: INT at E(2+P*PRESCALE); Mode 1 period = P*PRESCALE+2.
- When undefined: no prescaler; timing exactly as in Behaviour.

Test Plan:
- Reset then read: rst high 2 cycles; read BASE, BASE+4, BASE+8 -> dout=0 each; irq=0.
- One-shot: write PRESET=5, then CTRL=0b1001 (En=1, Mode 0, IM=1) at E0 -> COUNT reads 5,4,3,2,1 over E2..E6; irq=1 from E7 and stays high; CTRL[0] reads 0; writing CTRL=0 drops irq next cycle.
- Auto-reload: PRESET=3, CTRL=0b1011 (En=1, Mode 1, IM=1) -> irq 1-cycle pulses, 5 cycles apart, for at least 4 periods; CTRL=0b0011 (IM=0) -> irq stays 0 while COUNT keeps cycling.
- Stop and preset change mid-count: PRESET=10, start; at COUNT=6 write PRESET=2 -> COUNT continues 5,4,...; write En=0 at COUNT=4 -> COUNT frozen at 3 or 4; in Mode 1, the next reload uses 2.
- Decode and read-only checks:
  - Write 32'hDEAD_BEEF to BASE+8 -> COUNT unchanged.
  - Write to BASE+0x10 -> sel=0, no register changes.
  - Read BASE+0xC -> 0.
  - Reset asserted in CNT -> all registers 0 next edge.
- PRESET=0 edge case: Mode 0, IM=1 -> irq at E3; with TIMER_PRESCALE_EN and PRESCALE=4, PRESET=2 -> irq at E10.
